// File: rtl/nabp_projection_buffer_pkg.sv
// Shared definitions for the NABP ping-pong projection buffer:
// write-side FSM encoding and default geometry.
package nabp_projection_buffer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_SWAP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/nabp_bank_ram.sv
// One bank of the projection buffer: single write port, single
// synchronous read port, DEPTH x DATA_WIDTH.
module nabp_bank_ram
  import nabp_projection_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: storage carries no reset so it can map onto block RAM; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nabp_projection_buffer.sv
// Ping-pong projection buffer: one bank fills from upstream while the
// processing elements read the other; a buff_sel level change swaps them.
module nabp_projection_buffer
  import nabp_projection_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  buff_sel,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  fill_done,
  output logic                  swap_err
);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  buff_sel_q;
  logic                  swap_err_q, swap_err_d;
  logic                  rd_valid_q;
  logic                  rd_bank_q;
  logic                  swap_req;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] bank0_rd_data, bank1_rd_data;

  assign swap_req = (buff_sel != buff_sel_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_ready   = 1'b0;
    fill_done  = 1'b0;
    wr_fire    = 1'b0;
    swap_err_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_fire  = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          if (&wr_ptr_q) state_d = ST_FULL;
        end
      end
      ST_FULL: fill_done = 1'b1;
      ST_SWAP: begin
        wr_ptr_d = '0;
        state_d  = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
    // A swap request overrides everything: no write lands in the swap cycle.
    if (swap_req) begin
      wr_ready   = 1'b0;
      wr_fire    = 1'b0;
      wr_ptr_d   = '0;
      state_d    = ST_SWAP;
      swap_err_d = (state_q != ST_FULL);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buff_sel_q <= 1'b0;
      state_q    <= ST_FILL;
      wr_ptr_q   <= '0;
      swap_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      buff_sel_q <= buff_sel;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      swap_err_q <= swap_err_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_bank_q <= buff_sel_q;
    end
  end

  // buff_sel_q names the read bank; the write bank is always the other one.
  nabp_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
    .clk       (clk),
    .wr_en_i   (wr_fire & buff_sel_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en & ~buff_sel_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (bank0_rd_data)
  );

  nabp_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
    .clk       (clk),
    .wr_en_i   (wr_fire & ~buff_sel_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en & buff_sel_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (bank1_rd_data)
  );

  // Gating with rd_valid keeps rd_data at zero out of reset and between reads.
  assign rd_data   = rd_valid_q ? (rd_bank_q ? bank1_rd_data : bank0_rd_data) : '0;
  assign rd_valid  = rd_valid_q;
  assign swap_err  = swap_err_q;

endmodule

// File: tb/tb_nabp_projection_buffer.sv
// Directed scoreboard bench for nabp_projection_buffer with DEPTH=4.
module tb_nabp_projection_buffer;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          buff_sel;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          fill_done;
  logic          swap_err;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [DW-1:0] v_a[4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic [DW-1:0] v_b[4] = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
  logic [DW-1:0] v_d[4] = '{16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3};

  nabp_projection_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .buff_sel  (buff_sel),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fill_done (fill_done),
    .swap_err  (swap_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    rd_en   = 1'b1;
    rd_addr = addr;
    exp_q.push_back('{data, cyc});
  endtask

  // Monitor: every rd_valid must match the oldest queued read, one cycle after issue.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual rd_data=%h required no read", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", {16'h0, rd_data}, {16'h0, e.data});
        check("rd_latency", cyc, e.cyc + 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; buff_sel = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (2) tick();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_fill_done", fill_done, 0);
    check("rst_swap_err", swap_err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    tick(); reset_n = 1'b1;

    // Fill bank 1 with four samples; the fifth offer must be refused.
    for (int i = 0; i < 4; i++) begin
      tick(); wr_valid = 1'b1; wr_data = v_a[i];
      #1 check("fill_wr_ready", wr_ready, 1);
      check("fill_not_done", fill_done, 0);
    end
    tick(); wr_data = 16'h0055;
    #1 check("full_wr_ready", wr_ready, 0);
    check("full_fill_done", fill_done, 1);

    // Clean swap from FULL, then read back bank 1.
    tick(); wr_valid = 1'b0; buff_sel = 1'b1;
    #1 check("swapcyc_wr_ready", wr_ready, 0);
    tick();
    #1 check("clean_swap_err", swap_err, 0);
    check("swapst_fill_done", fill_done, 0);
    check("swapst_wr_ready", wr_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); rd(AW'(i), v_a[i]);
      #1 check("rd_phase_swap_err", swap_err, 0);
    end

    // Partial fill of bank 0, then swap with wr_valid held and a read in the swap cycle.
    tick(); rd_en = 1'b0; wr_valid = 1'b1; wr_data = 16'h00A0;
    tick(); wr_data = 16'h00A1;
    tick(); wr_data = 16'h00EE; buff_sel = 1'b0; rd(2'd0, 16'h0011);
    #1 check("early_swap_wr_ready", wr_ready, 0);
    check("early_swap_err_pre", swap_err, 0);
    tick(); wr_data = 16'h00EF; rd(2'd0, 16'h00A0);
    #1 check("early_swap_err", swap_err, 1);
    check("early_swapst_wr_ready", wr_ready, 0);
    check("early_swapst_fill_done", fill_done, 0);
    tick(); rd_en = 1'b0; wr_data = v_b[0];
    #1 check("early_swap_err_once", swap_err, 0);
    check("refill_wr_ready", wr_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick(); wr_data = v_b[i];
    end
    tick(); wr_valid = 1'b0;
    #1 check("refill_fill_done", fill_done, 1);
    tick(); buff_sel = 1'b1;
    tick();
    #1 check("second_swap_err", swap_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); rd(AW'(i), v_b[i]);
    end

    // Partial fill of bank 0 to wr_ptr=2 with a read in flight, then async reset.
    tick(); wr_valid = 1'b1; wr_data = 16'h00C0; rd_en = 1'b0;
    tick(); wr_data = 16'h00C1; rd_en = 1'b1; rd_addr = 2'd3;
    tick(); wr_valid = 1'b0; rd_en = 1'b0;
    check("pre_rst_rd_valid", rd_valid, 1);
    check("pre_rst_rd_data", rd_data, 32'h00B3);
    buff_sel = 1'b0;
    #1 check("pre_rst_swap_wr_ready", wr_ready, 0);
    reset_n = 1'b0;
    #1 check("async_rd_valid", rd_valid, 0);
    check("async_rd_data", rd_data, 0);
    check("async_fill_done", fill_done, 0);
    check("async_swap_err", swap_err, 0);
    check("async_wr_ready", wr_ready, 1);
    tick(); tick(); reset_n = 1'b1;

    // Refill after reset must target bank 1 from address 0.
    for (int i = 0; i < 4; i++) begin
      tick(); wr_valid = 1'b1; wr_data = v_d[i];
      #1 check("post_rst_wr_ready", wr_ready, 1);
    end
    tick(); wr_valid = 1'b0;
    #1 check("post_rst_fill_done", fill_done, 1);
    tick(); buff_sel = 1'b1;
    tick();
    #1 check("post_rst_swap_err", swap_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); rd(AW'(i), v_d[i]);
    end
    tick(); rd_en = 1'b0;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_outstanding actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nabp_projection_buffer.md
NABP_PROJECTION_BUFFER -- requirements
Module: nabp_projection_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one filtered projection sample.
REQ-002 Parameter ADDR_WIDTH, default 8, bank address width; DEPTH = 2**ADDR_WIDTH samples per bank.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 buff_sel  in  1  bank select level from state control; a level change requests a bank swap.
REQ-006 wr_valid  in  1  upstream sample valid.
REQ-007 wr_data  in  DATA_WIDTH  upstream projection sample.
REQ-008 wr_ready  out  1  buffer accepts a sample this cycle.
REQ-009 rd_en  in  1  processing-element read strobe.
REQ-010 rd_addr  in  ADDR_WIDTH  read address into the active bank.
REQ-011 rd_data  out  DATA_WIDTH  read data, one cycle after rd_en.
REQ-012 rd_valid  out  1  qualifies rd_data.
REQ-013 fill_done  out  1  level; the write bank holds DEPTH samples.
REQ-014 swap_err  out  1  one-cycle pulse; swap requested while the write bank was not full.

Function
REQ-015 Two banks; buff_sel_q (registered buff_sel) selects the read bank, ~buff_sel_q selects the write bank.
REQ-016 Swap cycle is any cycle with buff_sel != buff_sel_q; buff_sel_q takes buff_sel at the end of that cycle.
REQ-017 Write FSM states: FILL, FULL, SWAP (2-bit encoding).
REQ-018 FILL: wr_ready=1; a transfer occurs when wr_valid && wr_ready; it writes wr_data at wr_ptr and increments wr_ptr.
REQ-019 FILL -> FULL on the transfer at wr_ptr = DEPTH-1; wr_ptr wraps to 0.
REQ-020 FULL: wr_ready=0, fill_done=1; wr_valid is ignored.
REQ-021 Any state -> SWAP on a swap cycle; wr_ready=0 in the swap cycle, so no write occurs.
REQ-022 SWAP lasts one cycle: wr_ptr=0, fill_done=0, then -> FILL targeting the new write bank.
REQ-023 swap_err pulses in the cycle after a swap cycle whose FSM state was not FULL; the swap still completes.
REQ-024 A partially filled bank becoming the read bank keeps its stale contents; there is no clearing.
REQ-025 Read: rd_en in cycle N latches the read bank (buff_sel_q in cycle N) and rd_addr.
REQ-026 Read: rd_data and rd_valid=1 appear in cycle N+1; rd_valid=0 otherwise.
REQ-027 A read in the swap cycle returns data from the old read bank.
REQ-028 Read and write never target the same bank in one cycle; no bypass is required.
REQ-029 Reads remain legal in every FSM state.

Reset
REQ-030 On reset_n=0 asynchronously: buff_sel_q=0, state=FILL, wr_ptr=0, wr_ready=1 after release, fill_done=0, swap_err=0, rd_valid=0, rd_data=0.
REQ-031 Bank contents are not reset.
REQ-032 Reset mid-fill abandons the fill; writing restarts at bank 1, address 0.

Structure
REQ-033 Shared package holds the write FSM state encoding and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-034 Sub-module nabp_bank_ram: one-write, one-synchronous-read RAM of DEPTH x DATA_WIDTH, instantiated twice.

Verification (ADDR_WIDTH=2, DEPTH=4)
REQ-035 Reset, then stream 0x11,0x22,0x33,0x44 with wr_valid=1 -> wr_ready drops after the 4th transfer; fill_done=1.
REQ-036 After REQ-035, toggle buff_sel 0->1 and read addr 0..3 -> rd_data 0x11..0x44, each one cycle after rd_en; swap_err stays 0.
REQ-037 Toggle buff_sel after 2 of 4 writes -> swap_err pulses once; write pointer restarts at 0 in the other bank.
REQ-038 Hold wr_valid=1 through a swap cycle -> no write occurs in the swap cycle or the SWAP cycle; the next write lands at address 0.
REQ-039 Issue rd_en in the swap cycle -> data comes from the old bank; rd_en in the next cycle -> data comes from the new bank.
REQ-040 Assert reset_n=0 mid-fill at wr_ptr=2 -> all outputs reach their reset values immediately; refill starts at bank 1, address 0.
